and_test: RTL and testbench
===========================

Name: and_test

Overview:
- Bitwise AND unit with a zero-latency combinational result and a registered, valid-qualified result path.
- Saturating operation and hit counters for status and debug.
- Used as a leaf logic cell and self-test target in the single-cycle core's logic-unit area.
- With WIDTH=1, the combinational path is a plain 2-input AND gate.

Parameters:
- WIDTH, 1, operand and result bit width (1 to 64).
- CNT_W, 16, width of the op_count and hit_count status counters (4 to 32).

Ports:
- clk  input  1  rising-edge clock for all registered state.
- reset  input  1  synchronous, active-high reset.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- in_valid  input  1  qualifies A/B for the registered path and counters.
- Result  output  WIDTH  combinational A & B.
- Result_q  output  WIDTH  registered A & B, captured on in_valid.
- out_valid  output  1  Result_q was updated on the last clock edge.
- zero_q  output  1  registered flag: captured result was all zeros.
- op_count  output  CNT_W  number of accepted operations (saturating).
- hit_count  output  CNT_W  accepted operations whose result was all ones (saturating).
- cov_mask  output  4  bit0 input combinations seen (see Optional Feature).

Behaviour:
- Result = A & B, purely combinational with zero latency.
  - Independent of clk, reset and in_valid; valid even while reset is asserted.
  - Settles within the same delta/time step as input changes.
- All registered state updates only on the rising edge of clk.
- Reset (reset=1 at a clock edge) clears Result_q, out_valid, zero_q, op_count, hit_count and cov_mask to 0.
  - Reset has priority over in_valid in the same cycle.
  - A mid-operation reset discards the pending capture.
- Normal cycle, in_valid=1:
  - Result_q <= A & B.
  - zero_q <= ((A & B) == 0).
  - out_valid <= 1.
  - op_count increments by 1.
  - hit_count increments by 1 if A & B is all ones.
- Normal cycle, in_valid=0:
  - Result_q and zero_q hold.
  - out_valid <= 0.
  - Counters hold.
- Latency: registered result is available 1 cycle after acceptance; no backpressure, a new operand is accepted every cycle.
- Counters saturate at 2^CNT_W-1 and do not wrap. Further accepted operations leave them at max.
- X/Z on A/B with in_valid=0 has no effect on registered state.

Optional Feature:
- Macro: AND_TEST_COVER_EN.
- Defined:
  - cov_mask bit index {A[0],B[0]} (0..3) sets to 1 on each accepted operation with that combination.
  - Bits are sticky until reset.
  - cov_mask==4'b1111 means the full truth table was exercised.
- Not defined: cov_mask is tied to 4'b0000 and no coverage registers are synthesised.

Test Plan:
- WIDTH=1, no clock activity: drive A/B = 00, 01, 10, 11 for 10 time units each -> Result = 0, 0, 0, 1 respectively, sampled at the end of each interval.
- Assert reset for 2 cycles with in_valid=1, A=1, B=1 -> Result=1 combinationally; Result_q=0, out_valid=0, op_count=0, hit_count=0 after the reset edges.
- WIDTH=1, accept the four combinations on consecutive cycles with in_valid=1:
  - Result_q follows 0, 0, 0, 1 one cycle later.
  - zero_q follows 1, 1, 1, 0.
  - Final op_count=4, hit_count=1.
  - cov_mask=4'b1111 if AND_TEST_COVER_EN, else 0.
- WIDTH=8, A=8'hF0, B=8'h3C, in_valid=1 for one cycle, then in_valid=0 -> Result=8'h30 immediately; Result_q=8'h30 and out_valid=1 after the edge; on the next cycle out_valid=0 and Result_q holds 8'h30.
- CNT_W=4, 20 accepted operations with A=B=all ones -> op_count and hit_count stop at 15 and stay there.
- Reset asserted mid-stream while in_valid=1 -> all registered outputs are 0 at that edge; counting restarts from 1 on the next accepted operation.

Source files
------------

// File: rtl/and_test.sv
// Bitwise AND cell: combinational result plus a registered, valid-qualified
// result with saturating counters. Define AND_TEST_COVER_EN for sticky input coverage.
module and_test #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             in_valid,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] Result_q,
  output logic             out_valid,
  output logic             zero_q,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] hit_count,
  output logic [3:0]       cov_mask
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] RES_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] RES_ZERO = {WIDTH{1'b0}};

  logic [WIDTH-1:0] and_s;
  logic [WIDTH-1:0] res_q, res_d;
  logic             vld_q, vld_d;
  logic             zero_reg_q, zero_reg_d;
  logic [CNT_W-1:0] op_q, op_d;
  logic [CNT_W-1:0] hit_q, hit_d;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic en);
    if (en && (cnt != CNT_MAX)) begin
      return cnt + CNT_ONE;
    end else begin
      return cnt;
    end
  endfunction

  assign and_s  = A & B;
  assign Result = and_s;

  // Next-state for the registered result path and counters.
  always_comb begin
    res_d      = res_q;
    zero_reg_d = zero_reg_q;
    vld_d      = 1'b0;
    op_d       = op_q;
    hit_d      = hit_q;
    if (in_valid) begin
      res_d      = and_s;
      zero_reg_d = (and_s == RES_ZERO);
      vld_d      = 1'b1;
      op_d       = sat_inc(op_q, 1'b1);
      hit_d      = sat_inc(hit_q, (and_s == RES_ONES));
    end else begin
      vld_d      = 1'b0;
    end
  end

  // State registers with synchronous reset taking priority over capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_q      <= RES_ZERO;
      vld_q      <= 1'b0;
      zero_reg_q <= 1'b0;
      op_q       <= {CNT_W{1'b0}};
      hit_q      <= {CNT_W{1'b0}};
    end else begin
      res_q      <= res_d;
      vld_q      <= vld_d;
      zero_reg_q <= zero_reg_d;
      op_q       <= op_d;
      hit_q      <= hit_d;
    end
  end

  assign Result_q  = res_q;
  assign out_valid = vld_q;
  assign zero_q    = zero_reg_q;
  assign op_count  = op_q;
  assign hit_count = hit_q;

`ifdef AND_TEST_COVER_EN
  logic [3:0] cov_q, cov_d;

  // Bit {A[0],B[0]} marks that input pair as seen on an accepted operation.
  always_comb begin
    cov_d = cov_q;
    if (in_valid) begin
      cov_d = cov_q | (4'b0001 << {A[0], B[0]});
    end else begin
      cov_d = cov_q;
    end
  end

  // Sticky coverage register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cov_q <= 4'b0000;
    end else begin
      cov_q <= cov_d;
    end
  end

  assign cov_mask = cov_q;
`else
  assign cov_mask = 4'b0000;
`endif

endmodule

// File: tb/tb_and_test.sv
// Randomized self-checking bench for and_test: a WIDTH=1 and a WIDTH=8/CNT_W=4
// instance checked every cycle against a counting reference model.
module tb_and_test;

  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic reset = 1'b0;

  logic a1 = 1'b0, b1 = 1'b0, v1 = 1'b0;
  logic r1, rq1, ov1, z1;
  logic [15:0] op1, hit1;
  logic [3:0] cov1;

  logic [7:0] a8 = 8'h00, b8 = 8'h00;
  logic v8 = 1'b0;
  logic [7:0] r8, rq8;
  logic ov8, z8;
  logic [3:0] op8, hit8;
  logic [3:0] cov8;

  int checks = 0;
  int errors = 0;

  and_test #(.WIDTH(1), .CNT_W(16)) u_w1 (
    .clk(clk), .reset(reset), .A(a1), .B(b1), .in_valid(v1),
    .Result(r1), .Result_q(rq1), .out_valid(ov1), .zero_q(z1),
    .op_count(op1), .hit_count(hit1), .cov_mask(cov1)
  );

  and_test #(.WIDTH(8), .CNT_W(4)) u_w8 (
    .clk(clk), .reset(reset), .A(a8), .B(b8), .in_valid(v8),
    .Result(r8), .Result_q(rq8), .out_valid(ov8), .zero_q(z8),
    .op_count(op8), .hit_count(hit8), .cov_mask(cov8)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: operation tallies kept as plain unbounded integers.
  logic       mvalid = 1'b0;
  logic       m1_rq, m1_ov, m1_z;
  longint     m1_ops, m1_hits;
  logic [3:0] m1_seen;
  logic [7:0] m8_rq;
  logic       m8_ov, m8_z;
  longint     m8_ops, m8_hits;
  logic [3:0] m8_seen;

  function automatic longint sat(input longint n, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  function automatic logic [3:0] cov_exp(input logic [3:0] seen);
`ifdef AND_TEST_COVER_EN
    return seen;
`else
    return 4'b0000;
`endif
  endfunction

  always @(posedge clk) begin
    if (reset === 1'b1) begin
      mvalid <= 1'b1;
      m1_rq <= 1'b0; m1_ov <= 1'b0; m1_z <= 1'b0;
      m1_ops <= 0; m1_hits <= 0; m1_seen <= 4'b0000;
      m8_rq <= 8'h00; m8_ov <= 1'b0; m8_z <= 1'b0;
      m8_ops <= 0; m8_hits <= 0; m8_seen <= 4'b0000;
    end else begin
      m1_ov <= (v1 === 1'b1);
      if (v1 === 1'b1) begin
        m1_rq   <= a1 & b1;
        m1_z    <= ((a1 & b1) == 1'b0);
        m1_ops  <= m1_ops + 1;
        m1_hits <= m1_hits + ((a1 & b1) == 1'b1 ? 1 : 0);
        m1_seen[{a1, b1}] <= 1'b1;
      end
      m8_ov <= (v8 === 1'b1);
      if (v8 === 1'b1) begin
        m8_rq   <= a8 & b8;
        m8_z    <= ((a8 & b8) == 8'h00);
        m8_ops  <= m8_ops + 1;
        m8_hits <= m8_hits + ((a8 & b8) == 8'hFF ? 1 : 0);
        m8_seen[{a8[0], b8[0]}] <= 1'b1;
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (mvalid) begin
      chk("w1_result_q", 64'(rq1), 64'(m1_rq));
      chk("w1_out_valid", 64'(ov1), 64'(m1_ov));
      chk("w1_zero_q", 64'(z1), 64'(m1_z));
      chk("w1_op_count", 64'(op1), 64'(sat(m1_ops, 16)));
      chk("w1_hit_count", 64'(hit1), 64'(sat(m1_hits, 16)));
      chk("w1_cov_mask", 64'(cov1), 64'(cov_exp(m1_seen)));
      chk("w8_result_q", 64'(rq8), 64'(m8_rq));
      chk("w8_out_valid", 64'(ov8), 64'(m8_ov));
      chk("w8_zero_q", 64'(z8), 64'(m8_z));
      chk("w8_op_count", 64'(op8), 64'(sat(m8_ops, 4)));
      chk("w8_hit_count", 64'(hit8), 64'(sat(m8_hits, 4)));
      chk("w8_cov_mask", 64'(cov8), 64'(cov_exp(m8_seen)));
    end
  end

  task automatic drive_slot();
    @(negedge clk);
    #2;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] tt_exp;
  logic [3:0] cov_full;

  initial begin
    tt_exp = 4'b1000;
`ifdef AND_TEST_COVER_EN
    cov_full = 4'b1111;
`else
    cov_full = 4'b0000;
`endif

    // Pure gate behaviour with the clock stopped.
    for (int i = 0; i < 4; i++) begin
      {a1, b1} = 2'(i);
      a8 = 8'($urandom); b8 = 8'($urandom);
      #10;
      chk("tt_comb", 64'(r1), 64'(tt_exp[i]));
      chk("w8_comb", 64'(r8), 64'(a8 & b8));
    end
    #3;

    // Reset for two edges while offering an all-ones operation.
    reset = 1'b1; v1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
    v8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
    clk_en = 1'b1;
    after_edge();
    after_edge();
    chk("rst_comb", 64'(r1), 64'd1);
    chk("rst_result_q", 64'(rq1), 64'd0);
    chk("rst_out_valid", 64'(ov1), 64'd0);
    chk("rst_op_count", 64'(op1), 64'd0);
    chk("rst_hit_count", 64'(hit1), 64'd0);

    drive_slot();
    reset = 1'b0; v1 = 1'b0; v8 = 1'b0;

    // Full truth table accepted on consecutive cycles.
    for (int i = 0; i < 4; i++) begin
      if (i != 0) drive_slot();
      {a1, b1} = 2'(i); v1 = 1'b1;
      after_edge();
      chk("tt_result_q", 64'(rq1), 64'(tt_exp[i]));
      chk("tt_zero_q", 64'(z1), 64'(!tt_exp[i]));
    end
    drive_slot();
    v1 = 1'b0;
    after_edge();
    chk("tt_op_count", 64'(op1), 64'd4);
    chk("tt_hit_count", 64'(hit1), 64'd1);
    chk("tt_cov_mask", 64'(cov1), 64'(cov_full));
    chk("tt_idle_valid", 64'(ov1), 64'd0);

    // Single 8-bit operation followed by an idle cycle.
    drive_slot();
    a8 = 8'hF0; b8 = 8'h3C; v8 = 1'b1;
    #1;
    chk("w8_imm", 64'(r8), 64'h30);
    after_edge();
    chk("w8_result_q", 64'(rq8), 64'h30);
    chk("w8_valid", 64'(ov8), 64'd1);
    drive_slot();
    v8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    after_edge();
    chk("w8_idle_valid", 64'(ov8), 64'd0);
    chk("w8_hold", 64'(rq8), 64'h30);

    // Saturation of the 4-bit counters.
    for (int i = 0; i < 20; i++) begin
      drive_slot();
      a8 = 8'hFF; b8 = 8'hFF; v8 = 1'b1;
    end
    drive_slot();
    v8 = 1'b0;
    after_edge();
    chk("sat_op_count", 64'(op8), 64'd15);
    chk("sat_hit_count", 64'(hit8), 64'd15);

    // Unknown operands while idle must not disturb state.
    drive_slot();
    a1 = 1'bx; b1 = 1'bx; a8 = 8'hxx; b8 = 8'hxx;
    after_edge();
    drive_slot();
    chk("x_hold_op", 64'(op8), 64'd15);

    // Reset in the middle of a stream.
    a1 = 1'b1; b1 = 1'b1; v1 = 1'b1;
    a8 = 8'hFF; b8 = 8'hFF; v8 = 1'b1; reset = 1'b1;
    after_edge();
    chk("mid_result_q", 64'(rq1), 64'd0);
    chk("mid_valid", 64'(ov1), 64'd0);
    chk("mid_op_count", 64'(op1), 64'd0);
    chk("mid_cov_mask", 64'(cov1), 64'd0);
    drive_slot();
    reset = 1'b0;
    after_edge();
    chk("mid_restart_op", 64'(op1), 64'd1);
    chk("mid_restart_hit", 64'(hit1), 64'd1);
    chk("mid_restart_op8", 64'(op8), 64'd1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      drive_slot();
      a1 = 1'($urandom); b1 = 1'($urandom); v1 = 1'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        a8 = 8'hFF; b8 = 8'hFF;
      end else begin
        a8 = 8'($urandom); b8 = 8'($urandom);
      end
      v8 = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 40) == 0);
      #1;
      chk("rnd_comb1", 64'(r1), 64'(a1 & b1));
      chk("rnd_comb8", 64'(r8), 64'(a8 & b8));
    end
    drive_slot();
    v1 = 1'b0; v8 = 1'b0; reset = 1'b0;
    after_edge();
    clk_en = 1'b0;
    #20;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
